// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues the start bit, then shifts
// the byte, odd parity and stop bit out on device clock falls and checks the device ACK.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, ready for a new byte
// INHIBIT   | clock held low; start bit driven once the hold time expires
// SEND      | data bits, parity and stop driven on filtered clock falls
// ACK       | sample device acknowledge on the next fall
// WAIT_IDLE | wait for device to release both lines
// DONE      | one-cycle success pulse
// FAIL      | one-cycle error pulse (NACK or timeout), lines released
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall_q, fall_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          timeout;

  // Synchronizers reset to the idle-high line level so reset never fakes a fall.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d   = state_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    timeout   = (to_cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          data_d    = tx_data;
          par_d     = ~^tx_data;
          clk_oe_d  = 1'b1;
          inh_cnt_d = IW'(INHIBIT_CYCLES - 1);
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // Start bit goes out one cycle before the clock is released.
        if (data_oe_q) begin
          clk_oe_d  = 1'b0;
          to_cnt_d  = TW'(TIMEOUT_CYCLES - 1);
          bit_idx_d = '0;
          state_d   = S_SEND;
        end else if (inh_cnt_q == '0) begin
          data_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      S_SEND: begin
        if (timeout) begin
          state_d = S_FAIL;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
          if (fall_q) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
              data_oe_d = ~data_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              data_oe_d = ~par_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = S_ACK;
            end
          end
        end
      end
      S_ACK: begin
        if (timeout) begin
          state_d = S_FAIL;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
          if (fall_q) begin
            state_d = dat_s2_q ? S_FAIL : S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (timeout) begin
          state_d = S_FAIL;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
          if (filt_q && dat_s2_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAIL: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_FAIL) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      flt_cnt_q <= flt_cnt_d;
      fall_q    <= fall_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign rx_inhibit  = (state_q != S_IDLE);
  assign tx_done     = (state_q == S_DONE);
  assign tx_error    = (state_q == S_FAIL);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED set-LEDs, 0xFF reset and 0xF0 scan-set. It is the outbound counterpart of ps2_keyboard_interface and shares the same two open-drain PS/2 lines. It sits beside the keyboard receiver inside the tty block and is loaded from a bus-side valid/ready handshake. While it owns the lines it tells the receiver to ignore traffic.

Parameters:
INHIBIT_CYCLES, 5000, cycles the host holds ps2 clock low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles from clock release to the ACK sample (15 ms).
FILTER_LEN, 8, consecutive identical synchronized samples needed to accept a new ps2_clk level.

Ports:
clk_50mhz  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted in the cycle where tx_valid and tx_ready are both 1
tx_ready  out  1  1 only in IDLE
tx_done  out  1  one-cycle pulse on an acknowledged transfer
tx_error  out  1  one-cycle pulse on NACK or timeout
rx_inhibit  out  1  1 in every state except IDLE; the receiver drops frames while it is high
ps2_clk_in  in  1  raw PS/2 clock line level
ps2_data_in  in  1  raw PS/2 data line level
ps2_clk_oe  out  1  1 pulls the PS/2 clock line low; 0 releases it
ps2_data_oe  out  1  1 pulls the PS/2 data line low; 0 releases it

Behaviour:
- Reset (asynchronous, immediate):
  - ps2_clk_oe = 0, ps2_data_oe = 0, tx_done = 0, tx_error = 0.
  - State = IDLE, so tx_ready = 1 and rx_inhibit = 0.
  - Filtered clock = 1; all counters = 0.
  - Reset asserted mid-frame releases both lines in the same instant, with no clock edge required.
- Input conditioning:
  - 2-flop synchronizer on ps2_clk_in and on ps2_data_in.
  - Filtered clock changes only after FILTER_LEN equal consecutive samples.
  - fall = filtered clock 1 -> 0; this is the only event the bit logic uses.
- Accept: on tx_valid & tx_ready, latch the byte and compute parity = ~^tx_data (odd parity). tx_valid while not in IDLE is ignored; nothing is queued.
- FSM:
  - IDLE: no lines driven. On accept: go to INHIBIT, ps2_clk_oe = 1, counter = 0.
  - INHIBIT: count to INHIBIT_CYCLES-1, then set ps2_data_oe = 1 (start bit). Next cycle: ps2_clk_oe = 0, timeout counter = 0, go to SEND with bit index = 0.
  - SEND, on each fall:
    - index 0..7: ps2_data_oe = ~data[index] (LSB first).
    - index 8: ps2_data_oe = ~parity.
    - index 9: ps2_data_oe = 0 (stop bit = released).
    - Then index++. After index 9 is driven, go to ACK.
  - ACK: on the next fall, sample synchronized data. 0 means acknowledged: go to WAIT_IDLE. 1 means NACK: go to FAIL.
  - WAIT_IDLE: wait until filtered clock = 1 and synchronized data = 1, then go to DONE.
  - DONE: tx_done = 1 for exactly one cycle, then IDLE.
  - FAIL: both oe = 0, tx_error = 1 for exactly one cycle, then IDLE.
- Timeout:
  - Counts in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES, go to FAIL from any of those states.
  - If timeout and fall occur in the same cycle, timeout wins.
- Latency: ps2_data_oe changes exactly 1 cycle after the filtered fall is registered.
- tx_done and tx_error are never high together.
- Counters are sized with $clog2 of their parameter.
- The INHIBIT counter does not time out; the device cannot stall it.

Test Plan:
- Send 0xED (bench device model: 1000-cycle clock half-period, ACK asserted). Required: clock held low ≥ 5000 cycles; start bit 0; bits 1,0,1,1,0,1,1,1; parity 1; stop 1. tx_done pulses once, tx_ready returns to 1, both oe = 0.
- Parity coverage: 0x00 -> parity 1, 0x01 -> parity 0, 0xFF -> parity 1, 0x80 -> parity 0, each checked on the line sampled at the device-side rising edge.
- Device leaves data high at the ACK edge -> tx_error pulses one cycle, tx_done stays 0, lines released, IDLE.
- Device never clocks after release -> tx_error pulses exactly TIMEOUT_CYCLES cycles after ps2_clk_oe falls; rx_inhibit is 0 afterwards.
- rst_n driven low after data bit 3 -> both oe drop to 0 immediately without a clock edge; after release, 0x55 sends correctly.
- Inject a 3-cycle low glitch on the clock during SEND -> no bit advance. Pulse tx_valid with 0xAA mid-frame -> ignored; the original byte completes unchanged.
